dmem_access_ctrl: RTL and testbench

- Initiator side of the data-memory port. It drives dwe/addr/wdata into the team's synchronous dmem and captures its registered rdata.
- Accepts load/store requests from the MEM stage over a valid/ready handshake, buffers them in a small FIFO, and sequences each one through a 3-state FSM.
- Returns an in-order response pulse carrying load data or a store acknowledge.
- Flags out-of-range addresses without touching memory.

---
 rtl/dmem_access_ctrl_pkg.sv | 20 ++
 rtl/dmem_req_fifo.sv | 58 +++++
 rtl/dmem_access_ctrl.sv | 136 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared constants, FSM encoding and request-entry layout
package dmem_access_ctrl_pkg;

  localparam int DMEM_AW    = 8;
  localparam int DMEM_DW    = 16;
  localparam int DMEM_WORDS = 64;
  localparam int ENTRY_WE_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } dmem_state_e;

  // Request entry is packed as {we, addr, wdata}.
  function automatic int entry_width(input int aw, input int dw);
    return ENTRY_WE_W + aw + dw;
  endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// rtl/dmem_req_fifo.sv - request FIFO with registered full/empty flags
module dmem_req_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 2
) (
  input  logic             mem_clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [PW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (do_pop && !do_push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (PW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge mem_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - dmem initiator: queued load/store requests, in-order responses
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int DEPTH     = 2,
  parameter int MEM_WORDS = DMEM_WORDS
) (
  input  logic          reset,
  input  logic          mem_clk,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_we,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          dwe,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata
);

  localparam int          EW    = entry_width(AW, DW);
  localparam logic [AW:0] LIMIT = (AW+1)'(MEM_WORDS);

  dmem_state_e   state;
  dmem_state_e   state_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [EW-1:0] head;
  logic          head_we;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;
  logic          head_err;
  logic          err_pend;
  logic          err_we;

  assign {head_we, head_addr, head_wdata} = head;
  assign head_err  = ({1'b0, head_addr} >= LIMIT);
  assign req_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  dmem_req_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .mem_clk (mem_clk),
    .reset   (reset),
    .push    (req_valid && req_ready),
    .pop     (pop),
    .din     ({req_we, req_addr, req_wdata}),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // In ACCESS, dwe still holds the popped entry's we, so it doubles as the store flag.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!head_err) state_next = ST_ACCESS;
        end
      end
      ST_ACCESS:  state_next = dwe ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      dwe       <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      err_pend  <= 1'b0;
      err_we    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      err_pend  <= 1'b0;
      // An error response lands one edge after its pop, never colliding with an access response.
      if (err_pend) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_we    <= err_we;
        rsp_data  <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (head_err) begin
              err_pend <= 1'b1;
              err_we   <= head_we;
            end else begin
              addr  <= head_addr;
              wdata <= head_wdata;
              dwe   <= head_we;
            end
          end
        end
        ST_ACCESS: begin
          if (dwe) begin
            dwe       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
          end
        end
        ST_CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_we    <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl with a behavioural dmem
module tb_dmem_access_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    logic          we;
    logic          err;
    logic [DW-1:0] data;
    int            edge_exp;
  } rsp_t;

  logic          reset = 1'b0;
  logic          mem_clk = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_we;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          dwe;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  logic          preload;
  logic [DW-1:0] dmem [64];
  logic [DW-1:0] model_mem [64];
  rsp_t          sbq[$];
  logic [AW+DW-1:0] wq[$];
  rsp_t          m;
  logic [AW+DW-1:0] w;
  int            checks = 0;
  int            failures = 0;
  int            edge_cnt = 0;
  int            full_cnt = 0;

  dmem_access_ctrl #(.AW(AW), .DW(DW), .DEPTH(2), .MEM_WORDS(64)) dut (
    .reset     (reset),
    .mem_clk   (mem_clk),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_we    (rsp_we),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dwe       (dwe),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata)
  );

  always #5 mem_clk = ~mem_clk;

  always @(posedge mem_clk) edge_cnt <= edge_cnt + 1;

  always @(posedge mem_clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
      dmem[0] <= 16'hfffd;
      dmem[3] <= 16'hc369;
      dmem[6] <= 16'h0041;
      dmem[7] <= 16'h0001;
    end else if (dwe) begin
      dmem[addr[5:0]] <= wdata;
    end
    rdata <= dmem[addr[5:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge mem_clk) begin
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        m = sbq.pop_front();
        check_eq("rsp_we", {31'd0, rsp_we}, {31'd0, m.we});
        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, m.err});
        check_eq("rsp_data", {16'd0, rsp_data}, {16'd0, m.data});
        if (m.edge_exp != 0) check_eq("rsp_latency", edge_cnt, m.edge_exp);
      end
    end
    if (dwe) begin
      if (wq.size() == 0) begin
        check_eq("dwe_spurious", 32'd1, 32'd0);
      end else begin
        w = wq.pop_front();
        check_eq("dwe_addr", {24'd0, addr}, {24'd0, w[AW+DW-1:DW]});
        check_eq("dwe_wdata", {16'd0, wdata}, {16'd0, w[DW-1:0]});
      end
    end
    if (reset && !req_ready) full_cnt <= full_cnt + 1;
  end

  // Called and returns at a negedge; lat=0 skips the latency comparison.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
    rsp_t e;
    int   n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge mem_clk);
      n++;
    end
    check_eq("req_accept", {31'd0, req_ready}, 32'd1);
    e.we       = we;
    e.err      = (a >= 8'd64);
    e.data     = (we || e.err) ? '0 : model_mem[a[5:0]];
    e.edge_exp = (lat == 0) ? 0 : edge_cnt + 1 + lat;
    if (we && !e.err) begin
      model_mem[a[5:0]] = d;
      wq.push_back({a, d});
    end
    sbq.push_back(e);
    @(posedge mem_clk);
    @(negedge mem_clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 100) begin
      @(negedge mem_clk);
      n++;
    end
    check_eq("drain", sbq.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    preload   = 1'b1;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    model_mem[0] = 16'hfffd;
    model_mem[3] = 16'hc369;
    model_mem[6] = 16'h0041;
    model_mem[7] = 16'h0001;
    repeat (2) @(negedge mem_clk);

    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_we", {31'd0, rsp_we}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check_eq("rst_dwe", {31'd0, dwe}, 32'd0);
    check_eq("rst_addr", {24'd0, addr}, 32'd0);
    check_eq("rst_wdata", {16'd0, wdata}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    preload = 1'b0;
    reset   = 1'b1;
    @(negedge mem_clk);

    // loads of preloaded words
    send(1'b0, 8'd0, 16'h0, 3);
    send(1'b0, 8'd3, 16'h0, 0);
    wait_idle();

    // store then read-after-write
    send(1'b1, 8'd8, 16'h1234, 2);
    wait_idle();
    send(1'b0, 8'd8, 16'h0, 3);
    wait_idle();

    // back-to-back requests fill the two-entry FIFO
    f0 = full_cnt;
    send(1'b1, 8'd5, 16'haaaa, 2);
    send(1'b0, 8'd5, 16'h0, 0);
    send(1'b0, 8'd6, 16'h0, 0);
    send(1'b0, 8'd0, 16'h0, 0);
    wait_idle();
    check_eq("fifo_full_seen", {31'd0, (full_cnt > f0)}, 32'd1);

    // out-of-range store, then a normal load
    send(1'b1, 8'h40, 16'hbeef, 2);
    wait_idle();
    send(1'b0, 8'd0, 16'h0, 3);
    wait_idle();

    // reset while a store is in ACCESS
    send(1'b1, 8'd9, 16'h5555, 0);
    @(posedge mem_clk);
    @(negedge mem_clk);
    check_eq("abort_dwe_pre", {31'd0, dwe}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_dwe_async", {31'd0, dwe}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    sbq.delete();
    wq.delete();
    model_mem[9] = '0;
    repeat (3) @(negedge mem_clk);
    reset = 1'b1;
    check_eq("abort_no_write", {16'd0, dmem[9]}, 32'd0);
    check_eq("abort_req_ready", {31'd0, req_ready}, 32'd1);
    send(1'b0, 8'd7, 16'h0, 3);
    wait_idle();

    check_eq("wq_empty", wq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
